// File: rtl/w0rm_core_pkg.sv
// -----------------------------------------------------------------------------
// w0rm_core_pkg
// Shared types and constants for the w0rm core front end.
//   fetch_state_e  : fetch-stage run/halt state encoding
//   PC_ALIGN_MASK  : clears bit 0 of a redirect target (16-bit instruction
//                    alignment); sliced down to the PC width by the user
// -----------------------------------------------------------------------------
package w0rm_core_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    localparam logic [63:0] PC_ALIGN_MASK = ~64'h1;

endpackage

// File: rtl/w0rm_fetch_fifo.sv
// -----------------------------------------------------------------------------
// w0rm_fetch_fifo
// Synchronous first-word-fall-through FIFO with a clear input and occupancy
// count. The head entry is visible on pop_data_o whenever count_o != 0.
// Ports:
//   clk          clock
//   rst_n_i      synchronous active-low reset
//   clear_i      empties the FIFO; a same-cycle push or pop is ignored
//   push_i       write push_data_i
//   push_data_i  write data
//   pop_i        consume the head entry
//   pop_data_o   head entry (only meaningful when count_o != 0)
//   count_o      number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module w0rm_fetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;
    logic             full;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is only legal if the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (rst_n_i && !clear_i && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Upstream credit accounting must never push into a full FIFO.
    assert property (@(posedge clk) disable iff (!rst_n_i)
        !(push_i && full && !pop_i && !clear_i));

endmodule

// File: rtl/w0rm_core_ifetch.sv
// -----------------------------------------------------------------------------
// w0rm_core_ifetch
// Instruction fetch stage: owns the PC, issues in-order instruction memory
// requests under a credit limit, buffers responses in a prefetch FIFO and
// discards responses that were in flight when the pipeline was flushed.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   branch_valid, flush_pipeline,
//   next_pc_valid, next_pc            redirect interface from the branch unit
//   imem_req_valid/ready, imem_addr   instruction memory request
//   imem_resp_valid, imem_resp_data   in-order memory response (no backpressure)
//   decode_valid/ready, decode_inst,
//   decode_pc                         instruction stream to decode
//   perf_discard_count                (only with W0RM_IFETCH_PERF_EN) saturating
//                                     count of dropped responses plus cleared
//                                     buffer entries
// Build option: define W0RM_IFETCH_PERF_EN to add the discard counter.
// -----------------------------------------------------------------------------
module w0rm_core_ifetch
    import w0rm_core_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    INST_WIDTH   = 16,
    parameter int                    PC_INCREMENT = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  branch_valid,
    input  logic                  flush_pipeline,
    input  logic                  next_pc_valid,
    input  logic [DATA_WIDTH-1:0] next_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
`ifdef W0RM_IFETCH_PERF_EN
    output logic [15:0]           perf_discard_count,
`endif
    output logic                  decode_valid,
    input  logic                  decode_ready,
    output logic [INST_WIDTH-1:0] decode_inst,
    output logic [DATA_WIDTH-1:0] decode_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = DATA_WIDTH + INST_WIDTH;

    logic                  flush;
    logic                  redirect_pc;
    logic                  redirect;
    logic                  req_fire;
    logic                  resp_drop;
    logic                  resp_keep;
    logic                  dec_pop;
    logic [CW-1:0]         out_count;
    logic [CW-1:0]         buf_count;
    logic [CW:0]           credit_used;
    logic [DATA_WIDTH-1:0] resp_pc;
    logic [EW-1:0]         buf_head;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    fetch_state_e          state_q, state_d;
    logic [CW-1:0]         drop_q, drop_d;

    assign flush       = branch_valid && flush_pipeline;
    assign redirect_pc = branch_valid && next_pc_valid;
    assign redirect    = flush || redirect_pc;

    // Outstanding requests plus buffered entries may never exceed the FIFO
    // depth, so every response is guaranteed a slot.
    assign credit_used    = {1'b0, out_count} + {1'b0, buf_count};
    assign imem_req_valid = reset_n && (state_q == ST_RUN) && !redirect &&
                            (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && (drop_q != '0);
    assign resp_keep = imem_resp_valid && (drop_q == '0);
    assign dec_pop   = decode_valid && decode_ready;

    // Request-address queue: its occupancy is the outstanding count, and its
    // head is the address belonging to the next in-order response. Flushed
    // responses still pop it, so it is never cleared except by reset.
    w0rm_fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_req_tags (
        .clk         (clk),
        .rst_n_i     (reset_n),
        .clear_i     (1'b0),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (imem_resp_valid),
        .pop_data_o  (resp_pc),
        .count_o     (out_count)
    );

    w0rm_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .clk         (clk),
        .rst_n_i     (reset_n),
        .clear_i     (flush),
        .push_i      (resp_keep),
        .push_data_i ({resp_pc, imem_resp_data}),
        .pop_i       (dec_pop),
        .pop_data_o  (buf_head),
        .count_o     (buf_count)
    );

    assign decode_valid = (buf_count != '0);
    assign decode_inst  = decode_valid ? buf_head[INST_WIDTH-1:0] : '0;
    assign decode_pc    = decode_valid ? buf_head[EW-1:INST_WIDTH] : '0;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        drop_d  = drop_q;

        if (redirect_pc) begin
            pc_d = next_pc & PC_ALIGN_MASK[DATA_WIDTH-1:0];
        end else if (req_fire) begin
            pc_d = pc_q + DATA_WIDTH'(PC_INCREMENT);
        end

        if (redirect_pc) begin
            state_d = ST_RUN;
        end else if (flush) begin
            state_d = ST_HALT;
        end

        // Everything still in flight after this cycle belongs to the old stream.
        if (flush) begin
            drop_d = out_count - CW'(imem_resp_valid) + CW'(req_fire);
        end else if (resp_drop) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= RESET_VECTOR;
            state_q <= ST_RUN;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

`ifdef W0RM_IFETCH_PERF_EN
    logic [15:0] perf_q;
    logic [CW:0] discard_inc;
    logic [16:0] perf_sum;

    // On a flush, the buffered entries and any response arriving in that
    // cycle are all lost.
    assign discard_inc = flush ? ({1'b0, buf_count} + (CW + 1)'(imem_resp_valid))
                               : (CW + 1)'(resp_drop);
    assign perf_sum    = {1'b0, perf_q} + 17'(discard_inc);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_sum[16] ? 16'hFFFF : perf_sum[15:0];
        end
    end

    assign perf_discard_count = perf_q;
`endif

endmodule

// File: tb/tb_w0rm_core_ifetch.sv
module tb_w0rm_core_ifetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        branch_valid;
    logic        flush_pipeline;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [15:0] imem_resp_data;
    logic        decode_valid;
    logic        decode_ready;
    logic [15:0] decode_inst;
    logic [31:0] decode_pc;
`ifdef W0RM_IFETCH_PERF_EN
    logic [15:0] perf_discard_count;
`endif

    always #5 clk = ~clk;

    w0rm_core_ifetch dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .branch_valid    (branch_valid),
        .flush_pipeline  (flush_pipeline),
        .next_pc_valid   (next_pc_valid),
        .next_pc         (next_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
`ifdef W0RM_IFETCH_PERF_EN
        .perf_discard_count (perf_discard_count),
`endif
        .decode_valid    (decode_valid),
        .decode_ready    (decode_ready),
        .decode_inst     (decode_inst),
        .decode_pc       (decode_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int lat      = 1;
    int cyc      = 0;
    int fire_cnt = 0;
    bit addr_on  = 1'b0;
    bit sb_on    = 1'b0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_pc[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [15:0] inst_of(input logic [31:0] a);
        return a[15:0] ^ 16'hC35A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s: 0x%0h", name, act);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_addr(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_addr.push_back(base + 32'(2 * i));
    endtask

    task automatic push_pc(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_pc.push_back(base + 32'(2 * i));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_pc.size() != 0 || exp_addr.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        if (exp_pc.size() != 0 || exp_addr.size() != 0) begin
            fail_now(name, $sformatf("timeout, %0d decode and %0d request expectations left",
                                     exp_pc.size(), exp_addr.size()));
            exp_pc.delete();
            exp_addr.delete();
        end
        sb_on   = 1'b0;
        addr_on = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'h0);
        check({tag, "_addr"}, 64'(imem_addr), 64'h0);
        check({tag, "_dec_valid"}, 64'(decode_valid), 64'h0);
        check({tag, "_dec_inst"}, 64'(decode_inst), 64'h0);
        check({tag, "_dec_pc"}, 64'(decode_pc), 64'h0);
`ifdef W0RM_IFETCH_PERF_EN
        check({tag, "_perf"}, 64'(perf_discard_count), 64'h0);
`endif
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model with configurable latency; also checks request addresses
    // against the expected-request queue while that queue holds entries.
    initial begin : memory
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend_addr.delete();
                pend_due.delete();
                imem_resp_valid = 1'b0;
            end else begin
                if (pend_due.size() != 0 && pend_due[0] == cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = inst_of(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    imem_resp_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend_addr.push_back(imem_addr);
                    pend_due.push_back(cyc + lat);
                    fire_cnt++;
                    if (addr_on && exp_addr.size() != 0)
                        check("req_addr", 64'(imem_addr), 64'(exp_addr.pop_front()));
                end
            end
        end
    end

    // Scoreboard monitor: every decode handshake pops one expectation.
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && sb_on && decode_valid && decode_ready &&
                !(branch_valid && flush_pipeline)) begin
                if (exp_pc.size() == 0) begin
                    fail_now("dec_extra", $sformatf("unexpected pc 0x%0h", decode_pc));
                end else begin
                    e = exp_pc.pop_front();
                    check("dec_pc", 64'(decode_pc), 64'(e));
                    check("dec_inst", 64'(decode_inst), 64'(inst_of(e)));
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int k;
        reset_n        = 1'b0;
        branch_valid   = 1'b0;
        flush_pipeline = 1'b0;
        next_pc_valid  = 1'b0;
        next_pc        = '0;
        imem_req_ready = 1'b1;
        decode_ready   = 1'b1;
        tick(); tick(); tick();
        reset_checks("rst");

        // Streaming fetch, 1-cycle memory.
        push_addr(32'h0, 8);
        push_pc(32'h0, 8);
        addr_on = 1'b1;
        sb_on   = 1'b1;
        reset_n = 1'b1;
        drain("s1_drain");

        // Decode stalled: exactly FIFO_DEPTH requests, then release in order.
        reset_n = 1'b0;
        tick(); tick();
        decode_ready = 1'b0;
        fire_cnt = 0;
        push_addr(32'h0, 4);
        addr_on = 1'b1;
        reset_n = 1'b1;
        repeat (20) tick();
        check("s2_req_count", 64'(fire_cnt), 64'd4);
        check("s2_req_valid_low", 64'(imem_req_valid), 64'h0);
        check("s2_head_pc", 64'(decode_pc), 64'h0);
        check("s2_head_inst", 64'(decode_inst), 64'(inst_of(32'h0)));
        push_pc(32'h0, 8);
        sb_on = 1'b1;
        decode_ready = 1'b1;
        drain("s2_drain");

        // 3-cycle memory, flush to 0x101 with two requests in flight.
        reset_n = 1'b0;
        lat = 3;
        imem_req_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        push_addr(32'h0, 2);
        push_addr(32'h100, 3);
        push_pc(32'h100, 3);
        addr_on = 1'b1;
        sb_on   = 1'b1;
        imem_req_ready = 1'b1;
        tick(); tick();
        imem_req_ready = 1'b0;
        branch_valid   = 1'b1;
        flush_pipeline = 1'b1;
        next_pc_valid  = 1'b1;
        next_pc        = 32'h101;
        #1;
        check("s3_req_valid_redirect", 64'(imem_req_valid), 64'h0);
        tick();
        branch_valid   = 1'b0;
        flush_pipeline = 1'b0;
        next_pc_valid  = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("s3_req_valid_after", 64'(imem_req_valid), 64'h1);
        check("s3_addr_after", 64'(imem_addr), 64'h100);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s3_dec_idle%0d", i), 64'(decode_valid), 64'h0);
            tick();
        end
        drain("s3_drain");
`ifdef W0RM_IFETCH_PERF_EN
        check("s3_perf", 64'(perf_discard_count), 64'd2);
`endif

        // Flush without target: halt, then resume at 0x40.
        fire_cnt = 0;
        push_addr(32'h40, 3);
        push_pc(32'h40, 3);
        addr_on = 1'b1;
        sb_on   = 1'b1;
        branch_valid   = 1'b1;
        flush_pipeline = 1'b1;
        next_pc_valid  = 1'b0;
        tick();
        branch_valid   = 1'b0;
        flush_pipeline = 1'b0;
        repeat (20) tick();
        check("s4_halt_req_count", 64'(fire_cnt), 64'd0);
        check("s4_halt_req_valid", 64'(imem_req_valid), 64'h0);
        check("s4_halt_dec_valid", 64'(decode_valid), 64'h0);
        branch_valid  = 1'b1;
        next_pc_valid = 1'b1;
        next_pc       = 32'h40;
        #1;
        check("s4_resume_cycle_req", 64'(imem_req_valid), 64'h0);
        tick();
        branch_valid  = 1'b0;
        next_pc_valid = 1'b0;
        #1;
        check("s4_resume_req_valid", 64'(imem_req_valid), 64'h1);
        check("s4_resume_addr", 64'(imem_addr), 64'h40);
        drain("s4_drain");

        // PC wrap at the top of the address space.
        push_addr(32'hFFFF_FFFE, 3);
        push_pc(32'hFFFF_FFFE, 3);
        addr_on = 1'b1;
        sb_on   = 1'b1;
        branch_valid   = 1'b1;
        flush_pipeline = 1'b1;
        next_pc_valid  = 1'b1;
        next_pc        = 32'hFFFF_FFFE;
        tick();
        branch_valid   = 1'b0;
        flush_pipeline = 1'b0;
        next_pc_valid  = 1'b0;
        drain("s5_drain");

        // Reset with requests in flight and buffered entries.
        decode_ready = 1'b0;
        k = 0;
        while (!decode_valid && k < 50) begin
            tick();
            k++;
        end
        if (!decode_valid) fail_now("s6_fill", "decode_valid never rose");
        tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_checks("s6_rst");
        push_addr(32'h0, 3);
        push_pc(32'h0, 3);
        addr_on = 1'b1;
        sb_on   = 1'b1;
        decode_ready = 1'b1;
        reset_n = 1'b1;
        drain("s6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
